// File: rtl/bram_port_arbiter_if.sv
// Bus bundle for bram_port_arbiter: two requester ports, clear control and one BRAM port.
// Handshake: reqN/weN/addrN/dinN are held until gntN; gntN is combinational and the access
// happens in the cycle req&gnt are both high. rvalidN follows a granted read by one cycle.
interface bram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
);
  logic                  req0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic                  gnt0;
  logic                  rvalid0;

  logic                  req1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] din1;
  logic                  gnt1;
  logic                  rvalid1;

  logic [DATA_WIDTH-1:0] rdata;

  logic                  clear_start;
  logic                  clear_busy;
  logic                  clear_done;

  logic                  bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_din;
  logic [DATA_WIDTH-1:0] bram_dout;

  modport slave (
    input  req0, we0, addr0, din0, req1, we1, addr1, din1, clear_start, bram_dout,
    output gnt0, rvalid0, gnt1, rvalid1, rdata, clear_busy, clear_done,
           bram_we, bram_addr, bram_din
  );

  modport master (
    output req0, we0, addr0, din0, req1, we1, addr1, din1, clear_start, bram_dout,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata, clear_busy, clear_done,
           bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between two requesters, with an optional
// sequential clear engine compiled in by defining BRAM_ARB_CLEAR_EN.
module bram_port_arbiter #(
  parameter int                    ADDR_WIDTH  = 11,
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    DEPTH       = 1 << ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  bram_port_arbiter_if.slave  bus,
  output logic                dbg_state_o
);
  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;
  logic                  clr_go;
  logic                  pick0, pick1;
  logic                  gnt0, gnt1;
  logic                  bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_din;

`ifdef BRAM_ARB_CLEAR_EN
  // One extra counter bit lets DEPTH = 2^ADDR_WIDTH reach its last address without wrapping.
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic                clear_done_q, clear_done_d;
  assign clr_go = bus.clear_start;
`else
  localparam int                    depth_unused       = DEPTH;
  localparam logic [DATA_WIDTH-1:0] clear_value_unused = CLEAR_VALUE;
  logic clear_start_unused;
  assign clear_start_unused = bus.clear_start;
  assign clr_go             = 1'b0;
`endif

  // last_q names the requester served most recently; the other one wins a tie.
  assign pick0 = bus.req0 & (~bus.req1 | last_q);
  assign pick1 = bus.req1 & ~pick0;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    bram_we   = 1'b0;
    bram_addr = bus.addr0;
    bram_din  = bus.din0;
`ifdef BRAM_ARB_CLEAR_EN
    cnt_d        = cnt_q;
    clear_done_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (clr_go) begin
          state_d = S_CLEAR;
        end else if (pick0) begin
          gnt0      = 1'b1;
          bram_we   = bus.we0;
          rvalid0_d = ~bus.we0;
          last_d    = 1'b0;
        end else if (pick1) begin
          gnt1      = 1'b1;
          bram_we   = bus.we1;
          bram_addr = bus.addr1;
          bram_din  = bus.din1;
          rvalid1_d = ~bus.we1;
          last_d    = 1'b1;
        end
      end
`ifdef BRAM_ARB_CLEAR_EN
      S_CLEAR: begin
        bram_we   = 1'b1;
        bram_addr = cnt_q[ADDR_WIDTH-1:0];
        bram_din  = CLEAR_VALUE;
        if (cnt_q == LAST_ADDR) begin
          state_d      = S_IDLE;
          cnt_d        = '0;
          clear_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

`ifdef BRAM_ARB_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      clear_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign bus.clear_busy = (state_q == S_CLEAR);
  assign bus.clear_done = clear_done_q;
`else
  assign bus.clear_busy = 1'b0;
  assign bus.clear_done = 1'b0;
`endif

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata     = bus.bram_dout;
  assign bus.bram_we   = bram_we;
  assign bus.bram_addr = bram_addr;
  assign bus.bram_din  = bram_din;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Testbench for bram_port_arbiter: directed vector table, randomized traffic against a
// reference model, and clear/reset sequences when BRAM_ARB_CLEAR_EN is defined.
`timescale 1ns/1ps
module tb_bram_port_arbiter;
  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;
`ifdef BRAM_ARB_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic dbg_state;

  bram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bram_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .CLEAR_VALUE(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- BRAM model: one-cycle read latency, preset contents ----------------
  logic [DW-1:0] mem     [0:DEPTH-1];
  bit            written [0:DEPTH-1];

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    if (bus.bram_we) begin
      mem[bus.bram_addr]     <= bus.bram_din;
      written[bus.bram_addr] <= 1'b1;
    end
    bus.bram_dout <= written[bus.bram_addr] ? mem[bus.bram_addr] : init_word(bus.bram_addr);
  end

  // ---------------- reference model state + scoreboard ----------------
  int            n_tests = 0;
  int            n_fail  = 0;
  int            ref_last;   // requester served most recently
  int            clr_left;   // clear words still to write
  int            busy_cnt;
  int            done_cnt;
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  bit            ref_wr  [0:DEPTH-1];
  logic [DW-1:0] exp_q[$];

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : init_word(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver: one clock cycle, model prediction and checks ----------------
  task automatic cycle(
    input  logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
    input  logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
    input  logic cs,
    output logic o_g0, output logic o_g1, output logic o_we,
    output logic o_rv0, output logic o_rv1, output logic [DW-1:0] o_rd);
    logic e_g0, e_g1, e_we, e_busy, e_chk, start, e_done, p0, p1;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_rd;
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.din0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.din1 = d1;
    bus.clear_start = cs;
    e_g0 = 1'b0; e_g1 = 1'b0; e_we = 1'b0; e_chk = 1'b0; start = 1'b0;
    e_addr = '0; e_din = '0;
    e_busy = (clr_left > 0);
    if (clr_left > 0) begin
      e_we = 1'b1; e_addr = AW'(DEPTH - clr_left); e_din = '0; e_chk = 1'b1;
    end else if (CLEAR_EN && cs) begin
      start = 1'b1;
    end else if (r0 && (!r1 || ref_last == 1)) begin
      e_g0 = 1'b1; e_we = w0; e_addr = a0; e_din = d0; e_chk = 1'b1;
    end else if (r1) begin
      e_g1 = 1'b1; e_we = w1; e_addr = a1; e_din = d1; e_chk = 1'b1;
    end
    @(negedge clk);
    o_g0 = bus.gnt0; o_g1 = bus.gnt1; o_we = bus.bram_we;
    check("gnt0", 32'(bus.gnt0), 32'(e_g0));
    check("gnt1", 32'(bus.gnt1), 32'(e_g1));
    check("bram_we", 32'(bus.bram_we), 32'(e_we));
    check("clear_busy", 32'(bus.clear_busy), 32'(e_busy));
    check("dbg_state", 32'(dbg_state), 32'(e_busy));
    if (e_chk) check("bram_addr", 32'(bus.bram_addr), 32'(e_addr));
    if (e_we) check("bram_din", 32'(bus.bram_din), 32'(e_din));
    busy_cnt += int'(bus.clear_busy);
    p0 = e_g0 && !w0;
    p1 = e_g1 && !w1;
    if (p0) exp_q.push_back(ref_rd(a0));
    if (p1) exp_q.push_back(ref_rd(a1));
    if (e_we) begin
      ref_mem[e_addr] = e_din;
      ref_wr[e_addr]  = 1'b1;
    end
    e_done = 1'b0;
    if (clr_left > 0) begin
      clr_left--;
      e_done = (clr_left == 0);
    end else if (start) begin
      clr_left = DEPTH;
    end
    if (e_g0) ref_last = 0;
    if (e_g1) ref_last = 1;
    @(posedge clk);
    #1;
    o_rv0 = bus.rvalid0; o_rv1 = bus.rvalid1; o_rd = bus.rdata;
    check("rvalid0", 32'(bus.rvalid0), 32'(p0));
    check("rvalid1", 32'(bus.rvalid1), 32'(p1));
    check("clear_done", 32'(bus.clear_done), 32'(e_done));
    if (p0 || p1) begin
      e_rd = exp_q.pop_front();
      check("rdata", 32'(bus.rdata), 32'(e_rd));
    end
    done_cnt += int'(bus.clear_done);
  endtask

  task automatic do_reset();
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.clear_start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
    check("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
    check("rst_clear_busy", 32'(bus.clear_busy), 32'd0);
    check("rst_clear_done", 32'(bus.clear_done), 32'd0);
    check("rst_dbg_state", 32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ref_last = 1;
    clr_left = 0;
    exp_q.delete();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic r0; logic w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic r1; logic w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic g0; logic g1; logic we; logic rv0; logic rv1; logic [DW-1:0] rd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic g0, g1, we, rv0, rv1;
    logic [DW-1:0] rd;
    logic r0, w0, r1, w1, cs;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;

    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.din0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.din1 = '0;
    bus.clear_start = 1'b0;
    ref_last = 1; clr_left = 0; busy_cnt = 0; done_cnt = 0;

    //             r0 w0 a0       d0     r1 w1 a1       d1     g0 g1 we rv0 rv1 rd
    tbl[0]  = '{1, 0, 11'h030, 8'h00, 1, 0, 11'h041, 8'h00, 1, 0, 0, 1, 0, 8'h6A};
    tbl[1]  = '{1, 0, 11'h030, 8'h00, 1, 0, 11'h041, 8'h00, 0, 1, 0, 0, 1, 8'h1B};
    tbl[2]  = '{1, 0, 11'h030, 8'h00, 1, 0, 11'h041, 8'h00, 1, 0, 0, 1, 0, 8'h6A};
    tbl[3]  = '{1, 0, 11'h030, 8'h00, 1, 0, 11'h041, 8'h00, 0, 1, 0, 0, 1, 8'h1B};
    tbl[4]  = '{1, 1, 11'h010, 8'hA5, 0, 0, 11'h000, 8'h00, 1, 0, 1, 0, 0, 8'h00};
    tbl[5]  = '{1, 0, 11'h010, 8'h00, 0, 0, 11'h000, 8'h00, 1, 0, 0, 1, 0, 8'hA5};
    tbl[6]  = '{0, 0, 11'h000, 8'h00, 0, 0, 11'h000, 8'h00, 0, 0, 0, 0, 0, 8'h00};
    tbl[7]  = '{0, 0, 11'h000, 8'h00, 1, 1, 11'h7FF, 8'h11, 0, 1, 1, 0, 0, 8'h00};
    tbl[8]  = '{0, 0, 11'h000, 8'h00, 1, 0, 11'h7FF, 8'h00, 0, 1, 0, 0, 1, 8'h11};
    tbl[9]  = '{1, 1, 11'h000, 8'h22, 1, 0, 11'h000, 8'h00, 1, 0, 1, 0, 0, 8'h00};
    tbl[10] = '{0, 0, 11'h000, 8'h00, 1, 0, 11'h000, 8'h00, 0, 1, 0, 0, 1, 8'h22};
    tbl[11] = '{1, 0, 11'h010, 8'h00, 1, 0, 11'h7FF, 8'h00, 1, 0, 0, 1, 0, 8'hA5};

    do_reset();

    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
            tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1, 1'b0,
            g0, g1, we, rv0, rv1, rd);
      check($sformatf("tbl%0d_gnt0", i), 32'(g0), 32'(tbl[i].g0));
      check($sformatf("tbl%0d_gnt1", i), 32'(g1), 32'(tbl[i].g1));
      check($sformatf("tbl%0d_we", i), 32'(we), 32'(tbl[i].we));
      check($sformatf("tbl%0d_rv0", i), 32'(rv0), 32'(tbl[i].rv0));
      check($sformatf("tbl%0d_rv1", i), 32'(rv1), 32'(tbl[i].rv1));
      if (tbl[i].rv0 || tbl[i].rv1) check($sformatf("tbl%0d_rdata", i), 32'(rd), 32'(tbl[i].rd));
    end

    // Randomized traffic; clear_start pulses are included where the clear is compiled out.
    for (int i = 0; i < 400; i++) begin
      r0 = 1'($urandom_range(0, 1)); w0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
      a0 = ($urandom_range(0, 7) == 0) ? AW'(DEPTH - 1 - $urandom_range(0, 3)) : AW'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 7) == 0) ? AW'(DEPTH - 1 - $urandom_range(0, 3)) : AW'($urandom_range(0, 15));
      d0 = DW'($urandom_range(1, 255)); d1 = DW'($urandom_range(1, 255));
`ifdef BRAM_ARB_CLEAR_EN
      cs = 1'b0;
`else
      cs = ($urandom_range(0, 15) == 0);
`endif
      cycle(r0, w0, a0, d0, r1, w1, a1, d1, cs, g0, g1, we, rv0, rv1, rd);
    end

    // Reset mid-traffic restores the tie-break to requester 0.
    do_reset();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b0, 11'h003, 8'h00, 1'b1, 1'b0, 11'h005, 8'h00, 1'b0, g0, g1, we, rv0, rv1, rd);

`ifdef BRAM_ARB_CLEAR_EN
    // Full clear after random fill, with a re-pulse of clear_start mid-clear.
    busy_cnt = 0; done_cnt = 0;
    cycle(1'b1, 1'b1, 11'h000, 8'h77, 1'b0, 1'b0, 11'h000, 8'h00, 1'b1, g0, g1, we, rv0, rv1, rd);
    for (int i = 0; i < DEPTH + 4; i++) begin
      cs = (i == 1000) || ((i < DEPTH - 16) && ($urandom_range(0, 255) == 0));
      a0 = AW'($urandom_range(0, 15)); a1 = AW'($urandom_range(0, 15));
      cycle(1'($urandom_range(0, 1)), 1'b0, a0, 8'h00,
            1'($urandom_range(0, 1)), 1'b0, a1, 8'h00, cs, g0, g1, we, rv0, rv1, rd);
    end
    check("clear_busy_len", 32'(busy_cnt), 32'(DEPTH));
    check("clear_done_cnt", 32'(done_cnt), 32'd1);
    cycle(1'b1, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 11'h000, 8'h00, 1'b0, g0, g1, we, rv0, rv1, rd);
    check("clr_rd000_rv0", 32'(rv0), 32'd1);
    check("clr_rd000_data", 32'(rd), 32'd0);
    cycle(1'b0, 1'b0, 11'h000, 8'h00, 1'b1, 1'b0, 11'h7FF, 8'h00, 1'b0, g0, g1, we, rv0, rv1, rd);
    check("clr_rd7ff_rv1", 32'(rv1), 32'd1);
    check("clr_rd7ff_data", 32'(rd), 32'd0);

    // Refill a few words, then abort a clear by reset at address 0x100.
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 1'b1, AW'(16'h00FC + i), DW'(8'hC0 + i), 1'b0, 1'b0, 11'h000, 8'h00, 1'b0,
            g0, g1, we, rv0, rv1, rd);
    done_cnt = 0;
    cycle(1'b0, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 11'h000, 8'h00, 1'b1, g0, g1, we, rv0, rv1, rd);
    for (int i = 0; i < 256; i++)
      cycle(1'b0, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 11'h000, 8'h00, 1'b0, g0, g1, we, rv0, rv1, rd);
    do_reset();
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 11'h000, 8'h00, 1'b0, g0, g1, we, rv0, rv1, rd);
    check("abort_done_cnt", 32'(done_cnt), 32'd0);
    check("abort_busy", 32'(bus.clear_busy), 32'd0);
    cycle(1'b1, 1'b0, 11'h0FF, 8'h00, 1'b1, 1'b0, 11'h100, 8'h00, 1'b0, g0, g1, we, rv0, rv1, rd);
    cycle(1'b1, 1'b0, 11'h0FF, 8'h00, 1'b1, 1'b0, 11'h100, 8'h00, 1'b0, g0, g1, we, rv0, rv1, rd);

    // Fresh clear must start again from address 0.
    busy_cnt = 0; done_cnt = 0;
    cycle(1'b0, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 11'h000, 8'h00, 1'b1, g0, g1, we, rv0, rv1, rd);
    for (int i = 0; i < DEPTH + 2; i++)
      cycle(1'b0, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 11'h000, 8'h00, 1'b0, g0, g1, we, rv0, rv1, rd);
    check("restart_busy_len", 32'(busy_cnt), 32'(DEPTH));
    check("restart_done_cnt", 32'(done_cnt), 32'd1);
    cycle(1'b1, 1'b0, 11'h100, 8'h00, 1'b0, 1'b0, 11'h000, 8'h00, 1'b0, g0, g1, we, rv0, rv1, rd);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, SHALL set the BRAM address width.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the BRAM data width.
REQ-003 Parameter DEPTH, default 1<<ADDR_WIDTH, SHALL be the number of words covered by a clear.
REQ-004 Parameter CLEAR_VALUE, default 0, SHALL be the word written during a clear.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock shared with the BRAM.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 reqN (N=0,1)  input  1  requester N access request, held until granted.
REQ-009 weN  input  1  requester N write (1) / read (0), valid with reqN.
REQ-010 addrN  input  ADDR_WIDTH  requester N address, valid with reqN.
REQ-011 dinN  input  DATA_WIDTH  requester N write data, valid with reqN.
REQ-012 gntN  output  1  combinational grant; access is performed in this cycle.
REQ-013 rvalidN  output  1  one-cycle pulse: rdata holds requester N read data.
REQ-014 rdata  output  DATA_WIDTH  read data, wired from bram_dout.
REQ-015 clear_start  input  1  single-cycle pulse requesting a full clear.
REQ-016 clear_busy  output  1  high while a clear is in progress.
REQ-017 clear_done  output  1  one-cycle pulse when a clear completes.
REQ-018 bram_we, bram_addr, bram_din  output  1/ADDR_WIDTH/DATA_WIDTH  drive one BRAM port.
REQ-019 bram_dout  input  DATA_WIDTH  BRAM port read data, one-cycle read latency.

Function
REQ-020 States: IDLE (arbitrate requesters) and CLEAR (sequential fill); the state SHALL be registered.
REQ-021 In IDLE, if exactly one reqN is high, the block SHALL assert gntN and drive bram_* from requester N in the same cycle.
REQ-022 In IDLE, if both reqN are high, the block SHALL grant the requester not served last (round-robin); a registered last-served pointer SHALL update on every grant.
REQ-023 At most one gntN SHALL be high per cycle; with no request, bram_we SHALL be 0.
REQ-024 A granted read (weN=0) SHALL produce rvalidN=1 exactly one cycle after gntN, with rdata equal to the word at addrN.
REQ-025 A granted write SHALL NOT produce rvalidN.
REQ-026 Back-to-back grants SHALL be allowed every cycle, giving full port throughput.
REQ-027 clear_start while in IDLE SHALL move the block to CLEAR on the next edge; no grant SHALL be given in that cycle.
REQ-028 In CLEAR, the block SHALL write CLEAR_VALUE to addresses 0..DEPTH-1, one per cycle, in ascending order, with gnt0=gnt1=0.
REQ-029 After the DEPTH-1 write, the block SHALL pulse clear_done for one cycle, return to IDLE, and resume arbitration in that cycle.
REQ-030 clear_start while clear_busy=1 SHALL be ignored.
REQ-031 The clear address counter SHALL be ADDR_WIDTH+1 bits wide so that DEPTH = 2^ADDR_WIDTH terminates without wrap-around.
REQ-032 clear_busy SHALL equal (state==CLEAR).

Reset
REQ-033 While rst_n=0, the block SHALL set state=IDLE, last-served=1 (requester 0 wins the first tie), the clear counter to 0, rvalid0=rvalid1=0 and clear_done=0.
REQ-034 Reset during CLEAR SHALL abort the clear; on release, the block SHALL be in IDLE with no clear_done pulse.

Configuration
REQ-035 With macro BRAM_ARB_CLEAR_EN defined, the CLEAR state, counter and clear_* behaviour SHALL be compiled in.
REQ-036 Without BRAM_ARB_CLEAR_EN, clear_start SHALL be ignored, clear_busy and clear_done SHALL be tied to 0, and the block SHALL be IDLE-only; the ports SHALL remain present.

Verification
REQ-037 Write and read for requester 0: req0 writes 0xA5 to 0x010, then reads 0x010 -> gnt0 is high in each request cycle, and the next cycle shows rvalid0=1 with rdata=0xA5.
REQ-038 Simultaneous requests: req0 and req1 are both held high for 4 cycles after reset -> grants follow the order 0,1,0,1, and the rvalid pulses go to the matching requester.
REQ-039 Clear: after nonzero fill, pulse clear_start -> clear_busy stays high for 2048 cycles; requests see no grant; clear_done pulses once; reads of 0x000 and 0x7FF return 0x00.
REQ-040 Reset at clear address 0x100 -> after release, clear_busy=0 and clear_done was never pulsed; a fresh clear_start restarts at address 0x000.
REQ-041 clear_start is re-pulsed mid-clear -> the clear length is still 2048 cycles with a single clear_done pulse.
REQ-042 Build without BRAM_ARB_CLEAR_EN and pulse clear_start -> clear_busy=0, and arbitration is unaffected.
